sbit_acc_uni: RTL and testbench

Downstream stage of the 16-input unipolar temporal MAC. Converts the MAC's single-bit unipolar output stream back to a binary magnitude: it counts ones over a fixed window of 2^LOGLEN cycles and presents the count on a valid/ready output. A programmable skip phase discards the MAC's pipeline warm-up bits before counting starts.

---
 rtl/sbit_acc_uni.sv | 68 ++++++
 tb/tb_sbit_acc_uni.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sbit_acc_uni.sv
// sbit_acc_uni: counts ones in a unipolar bit stream over 2^LOGLEN cycles after a SKIP-cycle warm-up
// Ports: clk, rst (sync, active-high); start begins a run (IDLE, or DONE with iReady);
// iBit is the stream bit; iReady consumes the result; busy (SKIP/ACC); oValid (DONE); oC holds the count.
// Build option: define SBIT_ACC_SAT_EN to saturate a full-window count to 2^WIDTH-1 when WIDTH == LOGLEN.
module sbit_acc_uni #(
  parameter int LOGLEN = 8,
  parameter int WIDTH  = 8,
  parameter int SKIP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             iBit,
  input  logic             iReady,
  output logic             busy,
  output logic             oValid,
  output logic [WIDTH-1:0] oC
);
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACC, S_DONE} state_t;
  localparam state_t FIRST = (SKIP == 0) ? S_ACC : S_SKIP;
`ifdef SBIT_ACC_SAT_EN
  localparam bit SAT = (WIDTH == LOGLEN);
`else
  localparam bit SAT = 1'b0;
`endif
  state_t state, next;
  logic [3:0] skip_cnt;
  logic [LOGLEN-1:0] win_cnt;
  logic [LOGLEN:0] acc, total;
  logic [WIDTH-1:0] result;
  logic go;
  assign total  = acc + {{LOGLEN{1'b0}}, iBit};
  assign result = (SAT && total[LOGLEN]) ? '1 : WIDTH'(total);
  assign busy   = (state == S_SKIP) || (state == S_ACC);
  assign oValid = (state == S_DONE);
  always_comb begin
    go   = start && ((state == S_IDLE) || ((state == S_DONE) && iReady));
    next = state;
    case (state)
      S_IDLE:  next = start ? FIRST : S_IDLE;
      S_SKIP:  next = (skip_cnt == 4'(SKIP - 1)) ? S_ACC : S_SKIP;
      S_ACC:   next = (&win_cnt) ? S_DONE : S_ACC;
      default: next = iReady ? (start ? FIRST : S_IDLE) : S_DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      win_cnt  <= '0;
      acc      <= '0;
      oC       <= '0;
    end else begin
      state <= next;
      if (go) begin
        skip_cnt <= '0;
        win_cnt  <= '0;
        acc      <= '0;
      end else if (state == S_SKIP) begin
        skip_cnt <= skip_cnt + 4'd1;
      end else if (state == S_ACC) begin
        win_cnt <= win_cnt + 1'b1;
        acc     <= total;
      end
      if (state == S_ACC && &win_cnt) oC <= result;
    end
  end
endmodule

// File: tb/tb_sbit_acc_uni.sv
// tb_sbit_acc_uni: randomized self-checking bench for sbit_acc_uni against a window-sum reference model
module tb_sbit_acc_uni;
  localparam int SK = 2;
  localparam int NN = 256;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, iBit = 1'b0, iReady = 1'b0;
  logic busy, oValid, busy9, oValid9;
  logic [7:0] oC;
  logic [8:0] oC9;
  int checks = 0, errors = 0;
  int last8 = 0, last9 = 0;
  sbit_acc_uni #(.LOGLEN(8), .WIDTH(8), .SKIP(SK)) dut (
    .clk(clk), .rst(rst), .start(start), .iBit(iBit), .iReady(iReady),
    .busy(busy), .oValid(oValid), .oC(oC)
  );
  sbit_acc_uni #(.LOGLEN(8), .WIDTH(9), .SKIP(SK)) dut9 (
    .clk(clk), .rst(rst), .start(start), .iBit(iBit), .iReady(iReady),
    .busy(busy9), .oValid(oValid9), .oC(oC9)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int map8(input int c);
`ifdef SBIT_ACC_SAT_EN
    return (c > 255) ? 255 : c;
`else
    return c % 256;
`endif
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Entered in a cycle where the DUT is IDLE or DONE; that cycle is t. Returns in the last DONE cycle.
  task automatic run(input int mode, input int hold);
    int bits[SK+NN+1];
    int exp = 0;
    for (int k = 1; k <= SK + NN; k++) begin
      case (mode)
        1: bits[k] = 1;
        2: bits[k] = (k > SK) ? ((k - SK) % 2) : 1;
        3: bits[k] = 0;
        4: bits[k] = (k <= 2) ? 1 : 0;
        5: bits[k] = (k == 3) ? 1 : 0;
        default: bits[k] = int'($urandom_range(1));
      endcase
      if (k > SK) exp += bits[k];
    end
    start = 1'b1;
    iReady = 1'b1;
    iBit = 1'($urandom_range(1));
    step();
    for (int k = 1; k <= SK + NN; k++) begin
      iBit = bits[k][0];
      start = 1'($urandom_range(1));
      iReady = 1'($urandom_range(1));
      @(negedge clk);
      if (k == 1 || k == SK + NN || k % 64 == 0) begin
        check("busy_run", busy, 1);
        check("valid_low_run", oValid, 0);
      end
      step();
    end
    start = 1'b0;
    iReady = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      if (h < hold) start = 1'($urandom_range(1));
      @(negedge clk);
      check("valid_done", oValid, 1);
      check("busy_done", busy, 0);
      check("oc8", oC, map8(exp));
      check("oc9", oC9, exp);
      if (h < hold) step();
    end
    last8 = map8(exp);
    last9 = exp;
  endtask
  task automatic release_done();
    start = 1'b0;
    iReady = 1'b1;
    step();
    @(negedge clk);
    check("valid_pulse", oValid, 0);
    check("busy_idle", busy, 0);
    check("oc_hold", oC, last8);
    check("oc9_hold", oC9, last9);
    step();
  endtask
  initial begin
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", oValid, 0);
    check("rst_oc", oC, 0);
    rst = 1'b0;
    step();
    run(2, 0); release_done();
    run(1, 0); release_done();
    run(4, 0); release_done();
    run(5, 0); release_done();
    run(0, 10);
    run(0, 0); release_done();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= SK + 100; k++) begin
      iBit = (k > SK && k <= SK + 60) ? 1'b1 : 1'b0;
      step();
    end
    rst = 1'b1;
    step();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", oValid, 0);
    check("midrst_oc", oC, 0);
    check("midrst_oc9", oC9, 0);
    rst = 1'b0;
    step();
    run(3, 0); release_done();
    for (int r = 0; r < 4; r++) begin
      run(0, int'($urandom_range(3)));
      if (r % 2 == 1) release_done();
    end
    release_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
